// File: rtl/aes_out_serializer.sv
// aes_out_serializer: captures 128-bit ciphertext blocks on the rising edge of
// AES_data_out_valid into a small block FIFO and streams each block as four
// 32-bit words (MSW first) over a valid/ready interface.
module aes_out_serializer #(
  parameter int DEPTH = 2
) (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_data_out_valid,
  input  logic [127:0] AES_data_out,
  input  logic         ser_ready,
  input  logic         clr_overflow,
  output logic         ser_valid,
  output logic [31:0]  ser_data,
  output logic         ser_last,
  output logic [1:0]   ser_word_idx,
  output logic         buf_full,
  output logic         buf_empty,
  output logic         overflow,
  output logic [15:0]  blk_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, STREAM} state_t;

  logic [127:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  state_t        state_q, state_d;
  logic          prev_v_q;
  logic          ovf_q, ovf_d;
  logic [15:0]   blk_q, blk_d;

  logic          capture, xfer, pop, push_ok, drop;
  logic [127:0]  head;
  logic [31:0]   word;

  // ser_valid comes from state only, so ser_ready never reaches it combinationally.
  assign ser_valid = (state_q == STREAM);
  assign capture   = AES_data_out_valid & ~prev_v_q;
  assign xfer      = ser_valid & ser_ready;
  assign pop       = xfer & (idx_q == 2'd3);
  // A full FIFO still takes the push when the head is leaving on this edge.
  assign push_ok   = capture & ((cnt_q != FULL_CNT) | pop);
  assign drop      = capture & ~push_ok;

  // Next-state: pointers, occupancy, word index, FSM, sticky overflow, counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    blk_d    = blk_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      blk_d    = blk_q + 16'd1;
    end
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (xfer) idx_d = idx_q + 2'd1;   // 3 wraps to 0 on the pop
    // Set beats clear so a drop in the same cycle is never lost.
    if (drop)              ovf_d = 1'b1;
    else if (clr_overflow) ovf_d = 1'b0;
    // STREAM is held exactly while there is a block to send.
    state_d = (cnt_d != '0) ? STREAM : IDLE;
  end

  // State registers; prev_v resets high so a level held through reset is not captured.
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      state_q  <= IDLE;
      prev_v_q <= 1'b1;
      ovf_q    <= 1'b0;
      blk_q    <= 16'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      prev_v_q <= AES_data_out_valid;
      ovf_q    <= ovf_d;
      blk_q    <= blk_d;
    end
  end

  // Block storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge AES_clk) begin
    if (!AES_rst && push_ok) mem_q[wr_ptr_q] <= AES_data_out;
  end

  assign head = mem_q[rd_ptr_q];

  // Word select from the head entry, most significant word first.
  always_comb begin
    word = head[127:96];
    case (idx_q)
      2'd0: word = head[127:96];
      2'd1: word = head[95:64];
      2'd2: word = head[63:32];
      2'd3: word = head[31:0];
      default: word = head[127:96];
    endcase
  end

  assign ser_data     = ser_valid ? word : 32'd0;
  assign ser_last     = ser_valid & (idx_q == 2'd3);
  assign ser_word_idx = idx_q;
  assign buf_full     = (cnt_q == FULL_CNT);
  assign buf_empty    = (cnt_q == '0);
  assign overflow     = ovf_q;
  assign blk_count    = blk_q;

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed bench for aes_out_serializer (DEPTH=2): table-driven single block
// plus hand sequences for backpressure, level valid, overflow, full+pop and reset.
module tb_aes_out_serializer;

  logic         AES_clk = 1'b0;
  logic         AES_rst;
  logic         AES_data_out_valid;
  logic [127:0] AES_data_out;
  logic         ser_ready;
  logic         clr_overflow;
  logic         ser_valid;
  logic [31:0]  ser_data;
  logic         ser_last;
  logic [1:0]   ser_word_idx;
  logic         buf_full;
  logic         buf_empty;
  logic         overflow;
  logic [15:0]  blk_count;

  aes_out_serializer #(.DEPTH(2)) dut (
    .AES_clk(AES_clk), .AES_rst(AES_rst),
    .AES_data_out_valid(AES_data_out_valid), .AES_data_out(AES_data_out),
    .ser_ready(ser_ready), .clr_overflow(clr_overflow),
    .ser_valid(ser_valid), .ser_data(ser_data), .ser_last(ser_last),
    .ser_word_idx(ser_word_idx), .buf_full(buf_full), .buf_empty(buf_empty),
    .overflow(overflow), .blk_count(blk_count)
  );

  always #5 AES_clk = ~AES_clk;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic         v;
    logic [127:0] d;
    logic         r;
    logic         ev;
    logic [31:0]  ed;
    logic         el;
    logic [1:0]   ei;
    logic         ef;
    logic         ee;
    logic         eo;
    logic [15:0]  eb;
  } vec_t;

  vec_t tbl[7];

  localparam logic [127:0] KAT = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] BA  = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
  localparam logic [127:0] BB  = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
  localparam logic [127:0] BC  = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
  localparam logic [127:0] BD  = 128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3;
  localparam logic [127:0] BE  = 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3;
  localparam logic [127:0] BF  = 128'hF0F0F0F0_F1F1F1F1_F2F2F2F2_F3F3F3F3;

  logic [31:0] got[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge AES_clk);
    #1;
  endtask

  function automatic logic [31:0] wsel(input logic [127:0] b, input int i);
    return b[127-32*i -: 32];
  endfunction

  task automatic do_reset();
    AES_rst = 1'b1; AES_data_out_valid = 1'b0; AES_data_out = '0;
    ser_ready = 1'b0; clr_overflow = 1'b0;
    tick(); tick();
    AES_rst = 1'b0;
  endtask

  task automatic capture(input logic [127:0] b);
    AES_data_out = b; AES_data_out_valid = 1'b1; tick();
    AES_data_out_valid = 1'b0; tick();
  endtask

  // Hold ready high for n cycles, logging every word that transfers.
  task automatic run_ready(input int n);
    ser_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (ser_valid) got.push_back(ser_data);
      tick();
    end
  endtask

  task automatic chk_words(input string nm, input logic [127:0] b0, input logic [127:0] b1);
    chk({nm, "_nwords"}, got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk(nm, got[i], wsel(i < 4 ? b0 : b1, i % 4));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_valid"}, ser_valid, 0);
    chk({nm, "_data"},  ser_data, 0);
    chk({nm, "_last"},  ser_last, 0);
    chk({nm, "_idx"},   ser_word_idx, 0);
    chk({nm, "_full"},  buf_full, 0);
    chk({nm, "_empty"}, buf_empty, 1);
    chk({nm, "_ovf"},   overflow, 0);
    chk({nm, "_blk"},   blk_count, 0);
  endtask

  initial begin
    logic [31:0] prev_d;
    logic [1:0]  prev_i;
    logic        held;
    logic [6:0]  pat;
    int          nw;

    // Single block with ready=1: words appear the cycle after capture.
    tbl[0] = '{1'b0, KAT, 1'b1, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[1] = '{1'b1, KAT, 1'b1, 1'b1, 32'h69c4e0d8, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2] = '{1'b0, KAT, 1'b1, 1'b1, 32'h6a7b0430, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[3] = '{1'b0, KAT, 1'b1, 1'b1, 32'hd8cdb780, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[4] = '{1'b0, KAT, 1'b1, 1'b1, 32'h70b4c55a, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[5] = '{1'b0, KAT, 1'b1, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd1};
    tbl[6] = '{1'b0, KAT, 1'b1, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd1};

    do_reset();
    chk_reset_vals("rst");

    for (int i = 0; i < 7; i++) begin
      AES_data_out_valid = tbl[i].v; AES_data_out = tbl[i].d; ser_ready = tbl[i].r;
      tick();
      chk($sformatf("t%0d_valid", i), ser_valid, tbl[i].ev);
      chk($sformatf("t%0d_data", i),  ser_data, tbl[i].ed);
      chk($sformatf("t%0d_last", i),  ser_last, tbl[i].el);
      chk($sformatf("t%0d_idx", i),   ser_word_idx, tbl[i].ei);
      chk($sformatf("t%0d_full", i),  buf_full, tbl[i].ef);
      chk($sformatf("t%0d_empty", i), buf_empty, tbl[i].ee);
      chk($sformatf("t%0d_ovf", i),   overflow, tbl[i].eo);
      chk($sformatf("t%0d_blk", i),   blk_count, tbl[i].eb);
    end

    // Backpressure: ready pattern 1,0,0,1,0,1,1 from the first visible word.
    do_reset();
    tick();
    AES_data_out = KAT; AES_data_out_valid = 1'b1; tick();
    AES_data_out_valid = 1'b0;
    pat = 7'b1101001;   // bit i is ready in step i
    held = 1'b0; prev_d = '0; prev_i = '0;
    got.delete();
    for (int i = 0; i < 7; i++) begin
      ser_ready = pat[i];
      if (held) begin
        chk($sformatf("bp_hold_data%0d", i), ser_data, prev_d);
        chk($sformatf("bp_hold_idx%0d", i), ser_word_idx, prev_i);
        chk($sformatf("bp_hold_valid%0d", i), ser_valid, 1);
      end
      if (ser_valid && ser_ready) got.push_back(ser_data);
      held = ser_valid & ~ser_ready; prev_d = ser_data; prev_i = ser_word_idx;
      tick();
    end
    ser_ready = 1'b0; tick();
    chk("bp_nwords", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("bp_word", got[i], wsel(KAT, i));
    chk("bp_blk", blk_count, 1);
    chk("bp_empty", buf_empty, 1);
    chk("bp_valid", ser_valid, 0);

    // Level valid held 20 cycles: one block only.
    do_reset();
    tick();
    AES_data_out = KAT; AES_data_out_valid = 1'b1; ser_ready = 1'b1;
    nw = 0;
    for (int i = 0; i < 20; i++) begin
      if (ser_valid) nw++;
      tick();
    end
    AES_data_out_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ser_valid) nw++;
      tick();
    end
    chk("lvl_nwords", nw, 4);
    chk("lvl_blk", blk_count, 1);
    chk("lvl_empty", buf_empty, 1);

    // Overflow with ready low, then drain, then clear racing a new drop.
    do_reset();
    tick();
    capture(BA);
    chk("ovf_full1", buf_full, 0);
    capture(BB);
    chk("ovf_full2", buf_full, 1);
    chk("ovf_ovf2", overflow, 0);
    capture(BC);
    chk("ovf_ovf3", overflow, 1);
    chk("ovf_full3", buf_full, 1);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("ovf_clr", overflow, 0);
    got.delete();
    run_ready(12);
    chk_words("ovf_word", BA, BB);
    chk("ovf_blk", blk_count, 2);
    chk("ovf_empty", buf_empty, 1);
    ser_ready = 1'b0;
    capture(BD);
    capture(BE);
    clr_overflow = 1'b1; AES_data_out = BF; AES_data_out_valid = 1'b1; tick();
    chk("ovf_setwins", overflow, 1);
    clr_overflow = 1'b0; AES_data_out_valid = 1'b0; tick();
    chk("ovf_sticky", overflow, 1);

    // Full plus pop: capture edge lands on the idx=3 handshake.
    do_reset();
    tick();
    capture(BA);
    capture(BB);
    chk("fp_full", buf_full, 1);
    ser_ready = 1'b1;
    tick(); tick(); tick();
    chk("fp_idx3", ser_word_idx, 3);
    AES_data_out = BC; AES_data_out_valid = 1'b1; tick();
    AES_data_out_valid = 1'b0;
    chk("fp_ovf", overflow, 0);
    chk("fp_full_after", buf_full, 1);
    chk("fp_blk", blk_count, 1);
    chk("fp_head", ser_data, wsel(BB, 0));
    got.delete();
    run_ready(10);
    chk_words("fp_word", BB, BC);
    chk("fp_blk_end", blk_count, 3);

    // Reset mid-block with valid held high across it.
    do_reset();
    tick();
    AES_data_out = KAT; AES_data_out_valid = 1'b1; ser_ready = 1'b1;
    tick(); tick(); tick();
    chk("rm_idx2", ser_word_idx, 2);
    AES_rst = 1'b1; tick(); AES_rst = 1'b0;
    chk_reset_vals("rm");
    nw = 0;
    for (int i = 0; i < 5; i++) begin
      if (ser_valid) nw++;
      tick();
    end
    chk("rm_no_words", nw, 0);
    chk("rm_empty", buf_empty, 1);
    AES_data_out_valid = 1'b0; tick();
    AES_data_out_valid = 1'b1; tick();
    chk("rm_recap_valid", ser_valid, 1);
    chk("rm_recap_data", ser_data, wsel(KAT, 0));
    AES_data_out_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_out_serializer.md
# aes_out_serializer

Downstream consumer of `AES_top`. It captures each 128-bit ciphertext block presented on `AES_data_out`/`AES_data_out_valid` into a small block FIFO. It then streams each block as four 32-bit words over a valid/ready interface to the 32-bit system bus side. Blocks are never dropped silently: an overflow flag is raised instead.

## Interface
Parameters:
- `DEPTH`, default 2: number of 128-bit block entries. Must be a power of 2, range 2..8.

Ports:
- `AES_clk`: input, 1. Single clock for the whole block.
- `AES_rst`: input, 1. Reset is synchronous and active-high.
- `AES_data_out_valid`: input, 1. From `AES_top`. A block is captured on its rising edge.
- `AES_data_out`: input, 128. Ciphertext from `AES_top`.
- `ser_ready`: input, 1. Sink accepts a word.
- `clr_overflow`: input, 1. Clears sticky `overflow`.
- `ser_valid`: output, 1. Word available.
- `ser_data`: output, 32. Current word.
- `ser_last`: output, 1. Current word is word 3 of its block.
- `ser_word_idx`: output, 2. Index 0..3 of the current word.
- `buf_full`: output, 1. Block count equals `DEPTH`.
- `buf_empty`: output, 1. Block count is 0.
- `overflow`: output, 1. Sticky. Set when a block was dropped.
- `blk_count`: output, 16. Blocks fully emitted. Wraps modulo 2^16.

## Operation
- Edge detect:
  - `prev_v` registers `AES_data_out_valid`.
  - A capture event occurs when `AES_data_out_valid & ~prev_v`.
  - A level held high for many cycles yields exactly one capture.
- Push:
  - On a capture event, `AES_data_out` is written at `wr_ptr`, and `wr_ptr` and count are incremented.
  - Pointers are log2(`DEPTH`) bits and wrap naturally.
- Full with simultaneous pop: if the FIFO is full and a pop happens in the same cycle (final-word handshake), the push is accepted.
- Full without pop: the push is dropped, `overflow` is set, and the pointers are unchanged.
- Word order: `ser_word_idx` 0 maps to bits [127:96], 1 to [95:64], 2 to [63:32], 3 to [31:0] of the head entry.
- `ser_data` is 0 whenever `ser_valid` is 0.
- Handshake:
  - A transfer occurs when `ser_valid & ser_ready`.
  - While `ser_valid` is high and unaccepted, `ser_data`, `ser_last` and `ser_word_idx` are held stable.
  - `ser_valid` never deasserts without a transfer, except on reset.
- Read state machine:
  - IDLE (count = 0): `ser_valid` = 0. Go to STREAM when count becomes nonzero.
  - STREAM: `ser_valid` = 1.
    - A transfer with idx < 3 increments idx.
    - A transfer with idx = 3 pops the entry, resets idx to 0, and increments `blk_count`.
    - After a pop with count (after update) = 0, go to IDLE; otherwise stay in STREAM with the next entry.
- Count update: next count = count + push_accepted − pop. A simultaneous push and pop leaves count unchanged.
- `overflow`:
  - Set by a dropped push and cleared by `clr_overflow`.
  - If both happen in the same cycle, set wins.
- Reset (at any time, including mid-block):
  - Pointers, count and idx are cleared.
  - Any partially sent block is discarded.
  - `overflow` and `blk_count` are cleared, and the state returns to IDLE.
  - `prev_v` resets to 1, so a valid level held through reset is not captured as stale data.

## Timing
- Reset values: `ser_valid`=0, `ser_data`=0, `ser_last`=0, `ser_word_idx`=0, `buf_full`=0, `buf_empty`=1, `overflow`=0, `blk_count`=0.
- Latency: with a capture event sampled at edge N, `ser_valid`=1 with word 0 of that block is visible after edge N, i.e. in cycle N+1.
- Throughput:
  - With `ser_ready` held at 1, words move one per cycle.
  - A block takes 4 cycles.
  - Back-to-back blocks stream with no bubble.
- `buf_full`, `buf_empty` and `ser_last` are combinational from registered state and reflect the post-edge state in the same cycle.
- `blk_count` increments on the edge of the final-word transfer.
- No combinational path from `ser_ready` to `ser_valid`.

## Test plan
- Single block: after reset, pulse valid for 1 cycle with `AES_data_out`=69c4e0d8_6a7b0430_d8cdb780_70b4c55a and `ser_ready`=1.
  - Required: words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a in 4 consecutive cycles, starting 1 cycle after capture.
  - Required: `ser_last` high on the 4th word only, then `blk_count`=1 and `buf_empty`=1.
- Backpressure: same block with `ser_ready` toggling 1,0,0,1,0,1,1.
  - Required: each word is held stable while not ready.
  - Required: exactly 4 transfers in order, with no duplication.
- Level valid: hold valid high for 20 cycles.
  - Required: exactly one block is captured, `blk_count`=1.
- Overflow (`DEPTH`=2, `ser_ready`=0): capture 3 distinct blocks.
  - Required: `buf_full`=1 after the 2nd, `overflow`=1 after the 3rd.
  - Required: raising `ser_ready` then emits only blocks 1 and 2.
  - Required: `clr_overflow` asserted together with a new drop keeps `overflow`=1.
- Full plus pop: with the FIFO full, the capture edge coincides with the idx=3 handshake.
  - Required: the new block is accepted, `overflow` stays 0, and count stays at 2.
- Reset mid-block: assert `AES_rst` for 1 cycle after word 1 of a block, with valid held high across the reset.
  - Required: all outputs return to reset values.
  - Required: no further words are emitted and no capture occurs until valid falls and rises again.
